video_layer_arbiter: RTL and testbench
======================================

Name: video_layer_arbiter

Overview:
- Per-pixel compositor and scheduler for the VGA draw path.
- Inputs: the background/border generator (BG_RGB, boardersDrawReq) and NUM_LAYERS object drawers (drawReq + RGB each).
- Each pixel, it selects the highest-priority enabled layer and blinks layers on a frame cadence.
- Config writes are applied only at frame start; a border/player collision is flagged.
- Sits between the object drawers and the VGA output register.

Parameters:
- NUM_LAYERS, 4: number of object layers; index 0 = highest priority (player).
- BLINK_FRAMES, 15: frames per blink half-period; legal range 1..255.
- SEL_W, $clog2(NUM_LAYERS+1): width of selLayer (localparam).

Ports:
- clk  in  1  pixel clock
- reset  in  1  one clock; reset is synchronous and active-high
- startOfFrame  in  1  one-cycle pulse, coincident with pixelX=0, pixelY=0
- layerDrawReq  in  NUM_LAYERS  per-layer draw request, bit i = layer i
- layerRGB  in  NUM_LAYERS x 8  per-layer RGB332, packed array
- BG_RGB  in  8  background RGB332
- boardersDrawReq  in  1  border-line draw pulse from the background generator
- cfgWrite  in  1  one-cycle config write strobe
- cfgEnableMask  in  NUM_LAYERS  requested layer enables
- cfgBlinkMask  in  NUM_LAYERS  requested blink participation
- RGBOut  out  8  composited pixel
- selLayer  out  SEL_W  winning layer index; NUM_LAYERS = background
- collision  out  1  pulse: layer 0 drawn on a border pixel
- collisionFrame  out  1  sticky "collision this frame"
- blinkPhase  out  1  current blink phase (1 = blinking layers hidden)

Behaviour:
- FSM states: WAIT_SOF (reset state) and RUN.
  - WAIT_SOF -> RUN on startOfFrame.
  - RUN has no exit except reset.
- Reset values:
  - RGBOut=8'h00, selLayer=NUM_LAYERS, collision=0, collisionFrame=0, blinkPhase=0.
  - activeEnable=all 1s, activeBlink=0, pendingValid=0, blink counter=0.
  - Reset mid-frame discards any pending config and returns to WAIT_SOF on the next edge.
- Config shadowing:
  - cfgWrite captures both masks into pending registers and sets pendingValid.
  - Several writes before the next startOfFrame: the last one wins.
  - On startOfFrame with pendingValid=1: the pending masks move to the active registers and pendingValid clears.
  - cfgWrite and startOfFrame in the same cycle: the write data goes straight to the active registers (write wins); pendingValid ends at 0.
- Blink:
  - An 8-bit counter increments on every startOfFrame, in WAIT_SOF and in RUN.
  - When counter = BLINK_FRAMES-1 on a startOfFrame, it wraps to 0 and blinkPhase toggles.
  - BLINK_FRAMES=1 toggles the phase every frame.
- Arbitration, RUN only:
  - eff[i] = layerDrawReq[i] & activeEnable[i] & ~(activeBlink[i] & blinkPhase).
  - The lowest i with eff[i]=1 wins: RGBOut=layerRGB[i], selLayer=i.
  - No eff set: RGBOut=BG_RGB, selLayer=NUM_LAYERS.
  - Borders are already inside BG_RGB; they carry no priority of their own.
- Latency: exactly 1 clk from the inputs to RGBOut/selLayer/collision.
  - The pixel presented in the startOfFrame cycle is arbitrated with the pre-edge active config and blink phase.
- WAIT_SOF: RGBOut=8'h00, selLayer=NUM_LAYERS, collision=0, regardless of the inputs.
- Collision:
  - In RUN, collision <= eff[0] & boardersDrawReq.
  - Any collision sets collisionFrame.
  - startOfFrame clears collisionFrame; a collision in the same cycle wins (flag stays set).
- Widths:
  - Layer index and counter comparisons are unsigned.
  - No arithmetic on RGB; values pass through unmodified.

Decomposition:
- Shared package vga_pkg:
  - typedef rgb332_t (logic [7:0]).
  - Constant RGB_BLACK=8'h00.
  - enum arb_state_t {WAIT_SOF, RUN}.
- One natural sub-module: blink_frame_counter, containing the counter, wrap logic and blinkPhase, driven by startOfFrame and reset.
- The priority select stays in the top as a for-loop priority encoder.

Test Plan:
- Reset, then no startOfFrame, with layer0 drawReq=1 and RGB=8'hE0 -> RGBOut=8'h00, selLayer=4. Then pulse startOfFrame -> from the next pixel, RGBOut=8'hE0, selLayer=0.
- RUN with layers 1 and 3 requesting (RGB 8'h1C and 8'h03) and BG_RGB=8'h58 -> RGBOut=8'h1C, selLayer=1. Drop layer 1 -> 8'h03, selLayer=3. Drop all -> 8'h58, selLayer=4. Each result appears 1 clk after the input.
- cfgWrite with enable 4'b1110 mid-frame -> layer 0 is still drawn until the next startOfFrame, then masked. Two writes, 4'b1110 then 4'b0111, before startOfFrame -> 4'b0111 is applied.
- BLINK_FRAMES=3, cfgBlinkMask=4'b0001 -> blinkPhase toggles on every 3rd startOfFrame. Layer 0 is hidden while the phase is 1 and BG_RGB shows through.
- Layer0 drawReq and boardersDrawReq both high at pixelX=10 -> collision pulses for 1 cycle and collisionFrame=1, cleared at the next startOfFrame. Same with layer 0 disabled -> no collision.
- Assert reset mid-frame with a pending cfgWrite -> all outputs reach their reset values after 1 edge. At the next startOfFrame, enable stays all 1s (the pending write is lost).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA draw path.
package vga_pkg;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t RGB_BLACK = 8'h00;

    typedef enum logic {
        WAIT_SOF,
        RUN
    } arb_state_t;

endpackage

// File: rtl/blink_frame_counter.sv
// Frame counter that toggles blinkPhase every BLINK_FRAMES start-of-frame pulses.
module blink_frame_counter
    import vga_pkg::*;
#(
    parameter int BLINK_FRAMES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    output logic blinkPhase
);

    localparam logic [7:0] LAST_COUNT = 8'(BLINK_FRAMES - 1);

    logic [7:0] frameCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            frameCount <= 8'd0;
            blinkPhase <= 1'b0;
        end else if (startOfFrame) begin
            if (frameCount == LAST_COUNT) begin
                frameCount <= 8'd0;
                blinkPhase <= ~blinkPhase;
            end else begin
                frameCount <= frameCount + 8'd1;
            end
        end
    end

endmodule

// File: rtl/video_layer_arbiter.sv
// Per-pixel layer compositor: priority select over enabled layers, frame-synchronous
// config shadowing, blink masking and border/player collision flagging.
module video_layer_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int BLINK_FRAMES = 15,
    localparam int SEL_W       = $clog2(NUM_LAYERS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic [NUM_LAYERS-1:0]    layerDrawReq,
    input  rgb332_t [NUM_LAYERS-1:0] layerRGB,
    input  rgb332_t                  BG_RGB,
    input  logic                     boardersDrawReq,
    input  logic                     cfgWrite,
    input  logic [NUM_LAYERS-1:0]    cfgEnableMask,
    input  logic [NUM_LAYERS-1:0]    cfgBlinkMask,
    output rgb332_t                  RGBOut,
    output logic [SEL_W-1:0]         selLayer,
    output logic                     collision,
    output logic                     collisionFrame,
    output logic                     blinkPhase
);

    localparam logic [SEL_W-1:0] SEL_BG = SEL_W'(NUM_LAYERS);

    arb_state_t            state;
    logic [NUM_LAYERS-1:0] activeEnable;
    logic [NUM_LAYERS-1:0] activeBlink;
    logic [NUM_LAYERS-1:0] pendingEnable;
    logic [NUM_LAYERS-1:0] pendingBlink;
    logic                  pendingValid;

    logic [NUM_LAYERS-1:0] eff;
    rgb332_t               winRGB;
    logic [SEL_W-1:0]      winSel;
    logic                  hitNow;

    blink_frame_counter #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .reset       (reset),
        .startOfFrame(startOfFrame),
        .blinkPhase  (blinkPhase)
    );

    // Walk from lowest priority upward so the lowest requesting index overrides.
    always_comb begin
        eff    = layerDrawReq & activeEnable & ~(activeBlink & {NUM_LAYERS{blinkPhase}});
        winRGB = BG_RGB;
        winSel = SEL_BG;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff[i]) begin
                winRGB = layerRGB[i];
                winSel = SEL_W'(i);
            end
        end
        hitNow = (state == RUN) && eff[0] && boardersDrawReq;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_SOF;
            activeEnable   <= '1;
            activeBlink    <= '0;
            pendingEnable  <= '0;
            pendingBlink   <= '0;
            pendingValid   <= 1'b0;
            RGBOut         <= RGB_BLACK;
            selLayer       <= SEL_BG;
            collision      <= 1'b0;
            collisionFrame <= 1'b0;
        end else begin
            case (state)
                WAIT_SOF: begin
                    RGBOut   <= RGB_BLACK;
                    selLayer <= SEL_BG;
                    if (startOfFrame) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    RGBOut   <= winRGB;
                    selLayer <= winSel;
                end
                default: begin
                    state    <= WAIT_SOF;
                    RGBOut   <= RGB_BLACK;
                    selLayer <= SEL_BG;
                end
            endcase

            collision <= hitNow;
            if (hitNow) begin
                collisionFrame <= 1'b1;
            end else if (startOfFrame) begin
                collisionFrame <= 1'b0;
            end

            // A write coinciding with frame start bypasses the shadow registers.
            if (startOfFrame && cfgWrite) begin
                activeEnable <= cfgEnableMask;
                activeBlink  <= cfgBlinkMask;
                pendingValid <= 1'b0;
            end else if (startOfFrame && pendingValid) begin
                activeEnable <= pendingEnable;
                activeBlink  <= pendingBlink;
                pendingValid <= 1'b0;
            end else if (cfgWrite) begin
                pendingEnable <= cfgEnableMask;
                pendingBlink  <= cfgBlinkMask;
                pendingValid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_layer_arbiter.sv
// Directed bench with a scoreboard queue of expected pixels and a small reference model.
module tb_video_layer_arbiter;

    localparam int NL = 4;
    localparam int BF = 3;

    typedef struct packed {
        logic [7:0] rgb;
        logic [2:0] sel;
        logic       col;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 startOfFrame;
    logic [NL-1:0]        layerDrawReq;
    logic [NL-1:0][7:0]   layerRGB;
    logic [7:0]           BG_RGB;
    logic                 boardersDrawReq;
    logic                 cfgWrite;
    logic [NL-1:0]        cfgEnableMask;
    logic [NL-1:0]        cfgBlinkMask;
    logic [7:0]           RGBOut;
    logic [2:0]           selLayer;
    logic                 collision;
    logic                 collisionFrame;
    logic                 blinkPhase;

    video_layer_arbiter #(
        .NUM_LAYERS  (NL),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .layerDrawReq   (layerDrawReq),
        .layerRGB       (layerRGB),
        .BG_RGB         (BG_RGB),
        .boardersDrawReq(boardersDrawReq),
        .cfgWrite       (cfgWrite),
        .cfgEnableMask  (cfgEnableMask),
        .cfgBlinkMask   (cfgBlinkMask),
        .RGBOut         (RGBOut),
        .selLayer       (selLayer),
        .collision      (collision),
        .collisionFrame (collisionFrame),
        .blinkPhase     (blinkPhase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];

    // Reference model state
    logic          m_run, m_pv, m_phase, m_cf;
    logic [NL-1:0] m_en, m_bl, m_pen, m_pbl;
    int            m_cnt;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pv = 0; m_phase = 0; m_cf = 0; m_cnt = 0;
        m_en = '1; m_bl = '0; m_pen = '0; m_pbl = '0;
    endtask

    // One pixel: predict, clock, then compare the output produced for that pixel.
    task automatic cycle();
        logic [NL-1:0] eff;
        exp_t e, got;
        eff = layerDrawReq & m_en & ~(m_bl & {NL{m_phase}});
        e.rgb = 8'h00; e.sel = 3'd4; e.col = 1'b0;
        if (!reset && m_run) begin
            e.col = eff[0] & boardersDrawReq;
            if (eff[0])      begin e.rgb = layerRGB[0]; e.sel = 3'd0; end
            else if (eff[1]) begin e.rgb = layerRGB[1]; e.sel = 3'd1; end
            else if (eff[2]) begin e.rgb = layerRGB[2]; e.sel = 3'd2; end
            else if (eff[3]) begin e.rgb = layerRGB[3]; e.sel = 3'd3; end
            else             begin e.rgb = BG_RGB; end
        end
        sb.push_back(e);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (e.col) m_cf = 1;
            else if (startOfFrame) m_cf = 0;
            if (startOfFrame && cfgWrite) begin
                m_en = cfgEnableMask; m_bl = cfgBlinkMask; m_pv = 0;
            end else if (startOfFrame && m_pv) begin
                m_en = m_pen; m_bl = m_pbl; m_pv = 0;
            end else if (cfgWrite) begin
                m_pen = cfgEnableMask; m_pbl = cfgBlinkMask; m_pv = 1;
            end
            if (startOfFrame) begin
                m_run = 1;
                if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
                else m_cnt++;
            end
        end
        #1;
        got = {RGBOut, selLayer, collision};
        e = sb.pop_front();
        check("rgb", got.rgb, e.rgb);
        check("sel", {5'd0, got.sel}, {5'd0, e.sel});
        check("col", {7'd0, got.col}, {7'd0, e.col});
        check("colFrame", {7'd0, collisionFrame}, {7'd0, m_cf});
        check("blinkPhase", {7'd0, blinkPhase}, {7'd0, m_phase});
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
    endtask

    task automatic cfg_write(input logic [NL-1:0] en, input logic [NL-1:0] bl);
        cfgWrite = 1'b1; cfgEnableMask = en; cfgBlinkMask = bl;
        cycle();
        cfgWrite = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1; startOfFrame = 1'b0; layerDrawReq = '0;
        layerRGB[0] = 8'hE0; layerRGB[1] = 8'h1C; layerRGB[2] = 8'hAA; layerRGB[3] = 8'h03;
        BG_RGB = 8'h58; boardersDrawReq = 1'b0;
        cfgWrite = 1'b0; cfgEnableMask = '0; cfgBlinkMask = '0;
        repeat (2) cycle();
        reset = 1'b0;

        // Waiting for first frame: output held at black/background index
        layerDrawReq = 4'b0001;
        repeat (3) cycle();
        check("wait_rgb", RGBOut, 8'h00);
        check("wait_sel", {5'd0, selLayer}, 8'd4);
        sof_pulse();
        cycle();
        check("run_rgb", RGBOut, 8'hE0);
        check("run_sel", {5'd0, selLayer}, 8'd0);

        // Priority among layers and background fall-through
        layerDrawReq = 4'b1010; cycle();
        check("pri13", RGBOut, 8'h1C);
        layerDrawReq = 4'b1000; cycle();
        check("pri3", RGBOut, 8'h03);
        layerDrawReq = 4'b0000; cycle();
        check("bg", RGBOut, 8'h58);
        check("bg_sel", {5'd0, selLayer}, 8'd4);

        // Mid-frame config is shadowed until frame start
        layerDrawReq = 4'b1111;
        cfg_write(4'b1110, 4'b0000);
        cycle();
        check("shadow_hold", RGBOut, 8'hE0);
        sof_pulse();
        check("sof_preedge", RGBOut, 8'hE0);
        cycle();
        check("masked", RGBOut, 8'h1C);
        cfg_write(4'b1110, 4'b0000);
        cfg_write(4'b0111, 4'b0000);
        sof_pulse();
        cycle();
        check("last_wins", RGBOut, 8'hE0);

        // Write coinciding with frame start, then blink over several frames
        cfgWrite = 1'b1; cfgEnableMask = 4'b1111; cfgBlinkMask = 4'b0001;
        sof_pulse();
        cfgWrite = 1'b0;
        for (int f = 0; f < 8; f++) begin
            sof_pulse();
            repeat (3) begin
                layerDrawReq = 4'($urandom_range(0, 15));
                cycle();
            end
        end

        // Collision on a border pixel
        cfg_write(4'b1111, 4'b0000);
        sof_pulse();
        layerDrawReq = 4'b0001;
        for (int x = 0; x < 12; x++) begin
            boardersDrawReq = (x == 10);
            cycle();
            if (x == 10) begin
                check("col_pulse", {7'd0, collision}, 8'd1);
                check("col_frame", {7'd0, collisionFrame}, 8'd1);
            end
        end
        boardersDrawReq = 1'b0;
        check("col_done", {7'd0, collision}, 8'd0);
        boardersDrawReq = 1'b1;
        sof_pulse();
        check("col_sof_wins", {7'd0, collisionFrame}, 8'd1);
        boardersDrawReq = 1'b0;
        sof_pulse();
        check("col_cleared", {7'd0, collisionFrame}, 8'd0);
        cfg_write(4'b1110, 4'b0000);
        sof_pulse();
        boardersDrawReq = 1'b1;
        cycle();
        check("col_disabled", {7'd0, collision}, 8'd0);
        boardersDrawReq = 1'b0;

        // Reset mid-frame drops pending config
        cfg_write(4'b0000, 4'b0000);
        reset = 1'b1;
        cycle();
        check("rst_rgb", RGBOut, 8'h00);
        check("rst_sel", {5'd0, selLayer}, 8'd4);
        check("rst_phase", {7'd0, blinkPhase}, 8'd0);
        reset = 1'b0;
        cycle();
        sof_pulse();
        cycle();
        check("rst_enable", RGBOut, 8'hE0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
